tlb_lookup_unit: RTL and testbench
==================================

Name: tlb_lookup_unit

Overview:
Small fully-associative Sv39 TLB that sits directly upstream of the TLB bus unit. It takes translation requests from the load/store/fetch path, answers hits locally and checks permissions on them. On a miss it drives the bus unit's page-walk handshake and installs the returned entry. When a write hits an entry whose D bit is clear, it issues a write-through request so the bus unit sets D in memory.

Parameters:
ENTRY_NUM, 4, number of TLB entries (power of two, 2..16)
CNT_W, 32, width of performance counters (used only with TLB_PERF_CNT_EN)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
satp  in  64  CSR satp; MODE = satp[63:60]
mxr  in  1  CSR mstatus.MXR
sum  in  1  CSR mstatus.SUM
flush  in  1  sfence.vma, invalidate all entries
tsl_req  in  1  translation request, held until tsl_ready or tsl_page_fault
tsl_va  in  64  virtual address
tsl_read / tsl_write / tsl_execute  in  1 each  access type (one-hot)
tsl_priv  in  4  privilege: 0001 U, 0010 S, 1000 M
tsl_ready  out  1  one-cycle pulse, tsl_pa valid
tsl_pa  out  64  physical address
tsl_page_fault  out  1  one-cycle pulse
TLB_translate_req  out  1  walk request to bus unit
TLB_write_through_req  out  1  D-set request to bus unit
TLB_tsl_read / TLB_tsl_write / TLB_tsl_execute  out  1 each  latched access type
TLB_tsl_priv  out  4  latched privilege
TLB_PTE_out  out  64  PTE to write through
TLB_PTE_pa_out_va_out  out  64  va during walk, PTE physical address during write-through
TLB_PPN_in  in  44  walked PPN (4 KiB granule)
TLB_PTE_in  in  64  walked PTE
TLB_PTE_pa_in  in  64  walked PTE physical address
TLB_bu_ready  in  1  bus unit done
TLB_entry_write  in  1  fill strobe
TLB_D_set  in  1  write-through done
TLB_page_fault  in  1  walk or update fault

Behaviour:
- Reset: all outputs 0, all entry valid bits 0, round-robin pointer 0, flush_pend 0, state IDLE.
- Entry fields: valid, vpn = va[38:12], ppn[43:0], pte[63:0], pte_pa[63:0].
- Bare translation: satp MODE == 0 or tsl_priv == 1000. Result is tsl_pa = tsl_va, with no lookup and no fault.
- Permission fault on a hit:
  - U-mode access to a page with pte[4] == 0.
  - S-mode access to a page with pte[4] == 1, when sum == 0 or the access is execute.
  - read with !pte[1] & !(mxr & pte[3]).
  - write with !pte[2].
  - execute with !pte[3].
- FSM states:
  - IDLE: when tsl_req is seen, latch va, type and priv, then go to LOOKUP.
  - LOOKUP: bare → RESP. Hit with permission fail → FAULT. Hit with tsl_write and pte[7] == 0 → WTHRU. Hit otherwise → RESP, with tsl_pa = {8'b0, ppn, va[11:0]}. Miss → WALK. If several entries hit, the lowest index wins.
  - WALK: hold TLB_translate_req = 1 and drive TLB_PTE_pa_out_va_out = va. TLB_page_fault → FAULT. TLB_bu_ready → LOOKUP. TLB_translate_req stays high through the TLB_bu_ready cycle so the bus unit's TLB_entry_write is seen.
  - Fill on TLB_entry_write: the target is the lowest-index invalid entry; if none is invalid, the entry at the round-robin pointer. The pointer increments (mod ENTRY_NUM) on every fill that uses it.
  - WTHRU: hold TLB_write_through_req = 1, with TLB_PTE_out = entry.pte and TLB_PTE_pa_out_va_out = entry.pte_pa. TLB_D_set → set entry.pte[7] and go to RESP. TLB_page_fault → FAULT.
  - RESP: tsl_ready = 1 for one cycle, then IDLE.
  - FAULT: tsl_page_fault = 1 for one cycle, then IDLE.
- Latency: a hit with tsl_req seen in cycle 0 gives tsl_ready in cycle 2. A miss adds the walk plus one LOOKUP cycle.
- flush in IDLE: all valids cleared at the next edge; a tsl_req seen in the same cycle still proceeds to LOOKUP against the cleared array.
- flush in any other state: sets flush_pend. flush_pend is applied when the FSM enters IDLE, so the current access completes using the pre-flush contents.
- Requester dropping tsl_req mid-operation: the operation still runs to completion and the response pulse is ignored.
- tsl_pa holds its value until the next RESP.
- rst_n asserted mid-walk returns all state to reset immediately. The bus unit is reset in the same domain.

Optional Feature:
TLB_PERF_CNT_EN: defined → adds outputs hit_cnt and miss_cnt, each CNT_W wide.
- hit_cnt increments on each LOOKUP hit; miss_cnt increments on each LOOKUP miss.
- Bare LOOKUPs count as neither hits nor misses.
- Both counters saturate at all-ones and are cleared by reset only.
Undefined → neither port nor counter logic exists.

Test Plan:
- Bare mode: satp = 0, read va 0x8000_1234 → tsl_ready in cycle 2, tsl_pa = 0x8000_1234, TLB_translate_req never asserted.
- Miss then fill: satp MODE = 8, read va 0x4000_2010. Bus unit returns PPN 0x80005 with PTE V,R,A. Required: TLB_translate_req held until TLB_bu_ready, one fill, then tsl_pa = 0x8000_5010. A repeat read → tsl_ready in cycle 2 with no walk.
- Write hit with D = 0: the filled entry has pte_pa 0x8020_0010. Required: TLB_write_through_req with TLB_PTE_pa_out_va_out = 0x8020_0010. TLB_D_set → tsl_ready, and a second write needs no write-through.
- Permission: U-mode read of an S page (U = 0) → tsl_page_fault in cycle 2 with no bus activity. The same case in S-mode with sum = 0 and U = 1 → fault.
- Replacement and flush: five distinct vpns with ENTRY_NUM = 4 → the fifth evicts entry 0. flush during a WALK → the walk completes, the response is returned, and all valids are 0 in IDLE.
- Walk fault: TLB_page_fault during WALK → tsl_page_fault pulse and no entry written.

Source files
------------

// File: rtl/tlb_lookup_unit.sv
// tlb_lookup_unit: small fully-associative Sv39 TLB in front of the TLB bus unit.
// Hits are answered locally with a permission check. A miss drives the page-walk
// handshake and installs the returned entry. A write hit on a page with D clear
// goes through a write-through handshake so the bus unit can set D in memory.
// Optional build macro: TLB_PERF_CNT_EN adds saturating hit_cnt/miss_cnt outputs.
module tlb_lookup_unit #(
    parameter int ENTRY_NUM = 4,
    parameter int CNT_W     = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] satp,
    input  logic        mxr,
    input  logic        sum,
    input  logic        flush,
    input  logic        tsl_req,
    input  logic [63:0] tsl_va,
    input  logic        tsl_read,
    input  logic        tsl_write,
    input  logic        tsl_execute,
    input  logic [3:0]  tsl_priv,
    output logic        tsl_ready,
    output logic [63:0] tsl_pa,
    output logic        tsl_page_fault,
    output logic        TLB_translate_req,
    output logic        TLB_write_through_req,
    output logic        TLB_tsl_read,
    output logic        TLB_tsl_write,
    output logic        TLB_tsl_execute,
    output logic [3:0]  TLB_tsl_priv,
    output logic [63:0] TLB_PTE_out,
    output logic [63:0] TLB_PTE_pa_out_va_out,
    input  logic [43:0] TLB_PPN_in,
    input  logic [63:0] TLB_PTE_in,
    input  logic [63:0] TLB_PTE_pa_in,
    input  logic        TLB_bu_ready,
    input  logic        TLB_entry_write,
    input  logic        TLB_D_set,
    input  logic        TLB_page_fault
`ifdef TLB_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
`endif
);

    localparam int IDX_W = $clog2(ENTRY_NUM);

    localparam logic [3:0] PRIV_U = 4'b0001;
    localparam logic [3:0] PRIV_S = 4'b0010;
    localparam logic [3:0] PRIV_M = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WALK   = 3'd2,
        ST_WTHRU  = 3'd3,
        ST_RESP   = 3'd4,
        ST_FAULT  = 3'd5
    } state_e;

    // Returns 1 when the access described by rd/wr/ex/priv may not use this PTE.
    function automatic logic perm_fail(
        input logic [63:0] pte,
        input logic        rd,
        input logic        wr,
        input logic        ex,
        input logic [3:0]  priv,
        input logic        mxr_bit,
        input logic        sum_bit
    );
        logic fail;
        fail = 1'b0;
        if (priv == PRIV_U && !pte[4]) begin
            fail = 1'b1;
        end else if (priv == PRIV_S && pte[4] && (!sum_bit || ex)) begin
            fail = 1'b1;
        end else if (rd && !pte[1] && !(mxr_bit && pte[3])) begin
            fail = 1'b1;
        end else if (wr && !pte[2]) begin
            fail = 1'b1;
        end else if (ex && !pte[3]) begin
            fail = 1'b1;
        end else begin
            fail = 1'b0;
        end
        return fail;
    endfunction

    // FSM and request latch
    state_e            state_q, state_d;
    logic [63:0]       va_q;
    logic              rd_q, wr_q, ex_q;
    logic [3:0]        priv_q;
    logic [IDX_W-1:0]  hit_idx_q;
    logic              flush_pend_q, flush_pend_d;

    // Entry storage
    logic [ENTRY_NUM-1:0] valid_q;
    logic [26:0]          vpn_q    [ENTRY_NUM];
    logic [43:0]          ppn_q    [ENTRY_NUM];
    logic [63:0]          pte_q    [ENTRY_NUM];
    logic [63:0]          pte_pa_q [ENTRY_NUM];
    logic [IDX_W-1:0]     rr_q;

    // Registered outputs
    logic        tsl_ready_q;
    logic        tsl_page_fault_q;
    logic [63:0] tsl_pa_q;
    logic        translate_req_q;
    logic        wt_req_q;
    logic [63:0] pte_out_q;
    logic [63:0] pa_va_out_q;

    // Combinational helpers
    logic             bare_s;
    logic             hit_s;
    logic [IDX_W-1:0] hit_idx_s;
    logic             inv_found_s;
    logic [IDX_W-1:0] inv_idx_s;
    logic [IDX_W-1:0] fill_idx_s;
    logic [IDX_W-1:0] sel_idx_s;
    logic             perm_fail_s;
    logic [63:0]      pa_s;
    logic             fill_s;
    logic             dset_s;
    logic             clear_s;

    // Bits that carry no meaning for this block are folded into one sink.
    logic unused_ok_s;
    assign unused_ok_s = ^{satp[59:0], 32'(CNT_W)};

    // Bare translation when paging is off or the access is machine mode
    always_comb begin
        bare_s = (satp[63:60] == 4'd0) || (priv_q == PRIV_M);
    end

    // Associative match; scanning downwards leaves the lowest matching index
    always_comb begin
        hit_s     = 1'b0;
        hit_idx_s = {IDX_W{1'b0}};
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (valid_q[i] && (vpn_q[i] == va_q[38:12])) begin
                hit_s     = 1'b1;
                hit_idx_s = IDX_W'(i);
            end else begin
                hit_s     = hit_s;
                hit_idx_s = hit_idx_s;
            end
        end
    end

    // Fill target: lowest invalid entry, otherwise the round-robin victim
    always_comb begin
        inv_found_s = 1'b0;
        inv_idx_s   = {IDX_W{1'b0}};
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                inv_found_s = 1'b1;
                inv_idx_s   = IDX_W'(i);
            end else begin
                inv_found_s = inv_found_s;
                inv_idx_s   = inv_idx_s;
            end
        end
        if (inv_found_s) begin
            fill_idx_s = inv_idx_s;
        end else begin
            fill_idx_s = rr_q;
        end
    end

    // Entry selection, permission check and physical address formation
    always_comb begin
        if (state_q == ST_LOOKUP) begin
            sel_idx_s = hit_idx_s;
        end else begin
            sel_idx_s = hit_idx_q;
        end
        perm_fail_s = perm_fail(pte_q[hit_idx_s], rd_q, wr_q, ex_q, priv_q, mxr, sum);
        if ((state_q == ST_LOOKUP) && bare_s) begin
            pa_s = va_q;
        end else begin
            pa_s = {8'h00, ppn_q[sel_idx_s], va_q[11:0]};
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tsl_req) begin
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (bare_s) begin
                    state_d = ST_RESP;
                end else if (hit_s) begin
                    if (perm_fail_s) begin
                        state_d = ST_FAULT;
                    end else if (wr_q && !pte_q[hit_idx_s][7]) begin
                        state_d = ST_WTHRU;
                    end else begin
                        state_d = ST_RESP;
                    end
                end else begin
                    state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                if (TLB_page_fault) begin
                    state_d = ST_FAULT;
                end else if (TLB_bu_ready) begin
                    state_d = ST_LOOKUP;
                end else begin
                    state_d = ST_WALK;
                end
            end
            ST_WTHRU: begin
                if (TLB_page_fault) begin
                    state_d = ST_FAULT;
                end else if (TLB_D_set) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WTHRU;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_FAULT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Array update strobes and deferred-flush bookkeeping
    always_comb begin
        fill_s  = (state_q == ST_WALK) && TLB_entry_write;
        dset_s  = (state_q == ST_WTHRU) && TLB_D_set && !TLB_page_fault;
        clear_s = ((state_q == ST_IDLE) && flush) ||
                  ((state_q != ST_IDLE) && (state_d == ST_IDLE) && (flush_pend_q || flush));
        if (clear_s) begin
            flush_pend_d = 1'b0;
        end else if ((state_q != ST_IDLE) && flush) begin
            flush_pend_d = 1'b1;
        end else begin
            flush_pend_d = flush_pend_q;
        end
    end

    // FSM state and deferred-flush register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    // Capture the request when accepted in IDLE; remember which entry hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            va_q      <= 64'h0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ex_q      <= 1'b0;
            priv_q    <= 4'h0;
            hit_idx_q <= {IDX_W{1'b0}};
        end else begin
            if ((state_q == ST_IDLE) && tsl_req) begin
                va_q   <= tsl_va;
                rd_q   <= tsl_read;
                wr_q   <= tsl_write;
                ex_q   <= tsl_execute;
                priv_q <= tsl_priv;
            end
            if ((state_q == ST_LOOKUP) && hit_s) begin
                hit_idx_q <= hit_idx_s;
            end
        end
    end

    // Entry array: flush, fill from the walk, and D-bit set after write-through
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= {ENTRY_NUM{1'b0}};
            rr_q    <= {IDX_W{1'b0}};
            for (int i = 0; i < ENTRY_NUM; i++) begin
                vpn_q[i]    <= 27'h0;
                ppn_q[i]    <= 44'h0;
                pte_q[i]    <= 64'h0;
                pte_pa_q[i] <= 64'h0;
            end
        end else if (clear_s) begin
            valid_q <= {ENTRY_NUM{1'b0}};
        end else if (fill_s) begin
            valid_q[fill_idx_s]  <= 1'b1;
            vpn_q[fill_idx_s]    <= va_q[38:12];
            ppn_q[fill_idx_s]    <= TLB_PPN_in;
            pte_q[fill_idx_s]    <= TLB_PTE_in;
            pte_pa_q[fill_idx_s] <= TLB_PTE_pa_in;
            if (!inv_found_s) begin
                rr_q <= rr_q + IDX_W'(1);
            end
        end else if (dset_s) begin
            pte_q[hit_idx_q][7] <= 1'b1;
        end
    end

    // Outputs registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tsl_ready_q      <= 1'b0;
            tsl_page_fault_q <= 1'b0;
            tsl_pa_q         <= 64'h0;
            translate_req_q  <= 1'b0;
            wt_req_q         <= 1'b0;
            pte_out_q        <= 64'h0;
            pa_va_out_q      <= 64'h0;
        end else begin
            tsl_ready_q      <= (state_d == ST_RESP);
            tsl_page_fault_q <= (state_d == ST_FAULT);
            translate_req_q  <= (state_d == ST_WALK);
            wt_req_q         <= (state_d == ST_WTHRU);
            if (state_d == ST_RESP) begin
                tsl_pa_q <= pa_s;
            end
            if (state_d == ST_WTHRU) begin
                pte_out_q   <= pte_q[sel_idx_s];
                pa_va_out_q <= pte_pa_q[sel_idx_s];
            end else if (state_d == ST_WALK) begin
                pte_out_q   <= 64'h0;
                pa_va_out_q <= va_q;
            end else begin
                pte_out_q   <= 64'h0;
                pa_va_out_q <= 64'h0;
            end
        end
    end

    assign tsl_ready             = tsl_ready_q;
    assign tsl_page_fault        = tsl_page_fault_q;
    assign tsl_pa                = tsl_pa_q;
    assign TLB_translate_req     = translate_req_q;
    assign TLB_write_through_req = wt_req_q;
    assign TLB_tsl_read          = rd_q;
    assign TLB_tsl_write         = wr_q;
    assign TLB_tsl_execute       = ex_q;
    assign TLB_tsl_priv          = priv_q;
    assign TLB_PTE_out           = pte_out_q;
    assign TLB_PTE_pa_out_va_out = pa_va_out_q;

`ifdef TLB_PERF_CNT_EN
    logic [CNT_W-1:0] hit_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;
    logic             look_hit_s;
    logic             look_miss_s;

    // Classify translated LOOKUP cycles; bare lookups count as neither
    always_comb begin
        look_hit_s  = (state_q == ST_LOOKUP) && !bare_s && hit_s;
        look_miss_s = (state_q == ST_LOOKUP) && !bare_s && !hit_s;
    end

    // Saturating hit/miss counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= {CNT_W{1'b0}};
            miss_cnt_q <= {CNT_W{1'b0}};
        end else begin
            if (look_hit_s && (hit_cnt_q != {CNT_W{1'b1}})) begin
                hit_cnt_q <= hit_cnt_q + CNT_W'(1);
            end
            if (look_miss_s && (miss_cnt_q != {CNT_W{1'b1}})) begin
                miss_cnt_q <= miss_cnt_q + CNT_W'(1);
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_tlb_lookup_unit.sv
// Directed bench for tlb_lookup_unit with an inline bus-unit responder.
module tb_tlb_lookup_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] satp;
    logic        mxr, sum, flush;
    logic        tsl_req;
    logic [63:0] tsl_va;
    logic        tsl_read, tsl_write, tsl_execute;
    logic [3:0]  tsl_priv;
    logic        tsl_ready;
    logic [63:0] tsl_pa;
    logic        tsl_page_fault;
    logic        TLB_translate_req, TLB_write_through_req;
    logic        TLB_tsl_read, TLB_tsl_write, TLB_tsl_execute;
    logic [3:0]  TLB_tsl_priv;
    logic [63:0] TLB_PTE_out, TLB_PTE_pa_out_va_out;
    logic [43:0] TLB_PPN_in;
    logic [63:0] TLB_PTE_in, TLB_PTE_pa_in;
    logic        TLB_bu_ready, TLB_entry_write, TLB_D_set, TLB_page_fault;

    always #5 clk = ~clk;

    tlb_lookup_unit #(.ENTRY_NUM(4), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .satp(satp), .mxr(mxr), .sum(sum), .flush(flush),
        .tsl_req(tsl_req), .tsl_va(tsl_va), .tsl_read(tsl_read), .tsl_write(tsl_write),
        .tsl_execute(tsl_execute), .tsl_priv(tsl_priv), .tsl_ready(tsl_ready),
        .tsl_pa(tsl_pa), .tsl_page_fault(tsl_page_fault),
        .TLB_translate_req(TLB_translate_req), .TLB_write_through_req(TLB_write_through_req),
        .TLB_tsl_read(TLB_tsl_read), .TLB_tsl_write(TLB_tsl_write),
        .TLB_tsl_execute(TLB_tsl_execute), .TLB_tsl_priv(TLB_tsl_priv),
        .TLB_PTE_out(TLB_PTE_out), .TLB_PTE_pa_out_va_out(TLB_PTE_pa_out_va_out),
        .TLB_PPN_in(TLB_PPN_in), .TLB_PTE_in(TLB_PTE_in), .TLB_PTE_pa_in(TLB_PTE_pa_in),
        .TLB_bu_ready(TLB_bu_ready), .TLB_entry_write(TLB_entry_write),
        .TLB_D_set(TLB_D_set), .TLB_page_fault(TLB_page_fault)
    );

    localparam logic [2:0]  RD = 3'b100;
    localparam logic [2:0]  WR = 3'b010;
    localparam logic [3:0]  PU = 4'b0001;
    localparam logic [3:0]  PS = 4'b0010;
    localparam logic [3:0]  PM = 4'b1000;
    localparam logic [63:0] SV39 = 64'h8000_0000_0000_0000;

    int n_cmp = 0;
    int n_err = 0;

    // Bus-unit responder configuration
    logic [43:0] bu_ppn;
    logic [63:0] bu_pte, bu_pte_pa;
    bit          bu_fault;

    // Per-transaction observations
    int          lat, walk_cyc, wt_cyc;
    bit          got_ready, got_fault;
    logic [63:0] walk_va, wt_pa, wt_pte;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One request; responds to walk (after 3 cycles) and write-through (after 2 cycles).
    task automatic txn(input logic [63:0] va, input logic [2:0] typ, input logic [3:0] priv,
                       input bit flush_req, input bit flush_walk);
        bit done;
        int wcnt;
        tsl_va = va;
        {tsl_read, tsl_write, tsl_execute} = typ;
        tsl_priv = priv;
        tsl_req = 1'b1;
        flush = flush_req;
        done = 1'b0; wcnt = 0;
        lat = 0; walk_cyc = 0; wt_cyc = 0; got_ready = 1'b0; got_fault = 1'b0;
        walk_va = 64'h0; wt_pa = 64'h0; wt_pte = 64'h0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            flush = 1'b0;
            TLB_bu_ready = 1'b0; TLB_entry_write = 1'b0; TLB_page_fault = 1'b0; TLB_D_set = 1'b0;
            if (tsl_ready) begin got_ready = 1'b1; lat = k; done = 1'b1; end
            if (tsl_page_fault) begin got_fault = 1'b1; lat = k; done = 1'b1; end
            if (TLB_translate_req) begin
                walk_cyc++;
                walk_va = TLB_PTE_pa_out_va_out;
                if (flush_walk && walk_cyc == 1) flush = 1'b1;
                wcnt++;
                if (wcnt == 3) begin
                    if (bu_fault) begin
                        TLB_page_fault = 1'b1;
                    end else begin
                        TLB_PPN_in = bu_ppn; TLB_PTE_in = bu_pte; TLB_PTE_pa_in = bu_pte_pa;
                        TLB_bu_ready = 1'b1; TLB_entry_write = 1'b1;
                    end
                end
            end
            if (TLB_write_through_req) begin
                wt_cyc++;
                wt_pa = TLB_PTE_pa_out_va_out;
                wt_pte = TLB_PTE_out;
                if (wt_cyc == 2) TLB_D_set = 1'b1;
            end
        end
        tsl_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; satp = 64'h0; mxr = 1'b0; sum = 1'b0; flush = 1'b0;
        tsl_req = 1'b0; tsl_va = 64'h0; tsl_read = 1'b0; tsl_write = 1'b0; tsl_execute = 1'b0;
        tsl_priv = 4'h0; TLB_PPN_in = 44'h0; TLB_PTE_in = 64'h0; TLB_PTE_pa_in = 64'h0;
        TLB_bu_ready = 1'b0; TLB_entry_write = 1'b0; TLB_D_set = 1'b0; TLB_page_fault = 1'b0;
        bu_ppn = 44'h0; bu_pte = 64'h0; bu_pte_pa = 64'h0; bu_fault = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("rst_ready", {63'h0, tsl_ready}, 64'h0);
        chk("rst_fault", {63'h0, tsl_page_fault}, 64'h0);
        chk("rst_walk", {63'h0, TLB_translate_req}, 64'h0);
        chk("rst_wt", {63'h0, TLB_write_through_req}, 64'h0);
        chk("rst_pa", tsl_pa, 64'h0);
        chk("rst_vaout", TLB_PTE_pa_out_va_out, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bare: paging off
        txn(64'h8000_1234, RD, PS, 1'b0, 1'b0);
        chk("bare_ready", {63'h0, got_ready}, 64'h1);
        chk("bare_lat", 64'(lat), 64'd2);
        chk("bare_pa", tsl_pa, 64'h8000_1234);
        chk("bare_walk", 64'(walk_cyc), 64'd0);
        chk("pulse_one", {63'h0, tsl_ready}, 64'h0);
        chk("priv_latch", {60'h0, TLB_tsl_priv}, 64'h2);

        // Bare: machine mode under Sv39
        satp = SV39;
        txn(64'h1234_5678, RD, PM, 1'b0, 1'b0);
        chk("m_pa", tsl_pa, 64'h1234_5678);
        chk("m_walk", 64'(walk_cyc), 64'd0);

        // Miss then fill; V,R,A
        bu_ppn = 44'h80005; bu_pte = 64'h43; bu_pte_pa = 64'h8010_0000;
        txn(64'h4000_2010, RD, PS, 1'b0, 1'b0);
        chk("miss_ready", {63'h0, got_ready}, 64'h1);
        chk("miss_walk", 64'(walk_cyc), 64'd3);
        chk("miss_va", walk_va, 64'h4000_2010);
        chk("miss_lat", 64'(lat), 64'd6);
        chk("miss_pa", tsl_pa, 64'h8000_5010);
        txn(64'h4000_2010, RD, PS, 1'b0, 1'b0);
        chk("rehit_lat", 64'(lat), 64'd2);
        chk("rehit_walk", 64'(walk_cyc), 64'd0);
        chk("rehit_pa", tsl_pa, 64'h8000_5010);

        // Write with D clear -> write-through; V,R,W,A
        bu_ppn = 44'h80006; bu_pte = 64'h47; bu_pte_pa = 64'h8020_0010;
        txn(64'h5008, WR, PS, 1'b0, 1'b0);
        chk("wt_ready", {63'h0, got_ready}, 64'h1);
        chk("wt_cyc", 64'(wt_cyc), 64'd2);
        chk("wt_pa", wt_pa, 64'h8020_0010);
        chk("wt_pte", wt_pte, 64'h47);
        chk("wt_tslpa", tsl_pa, 64'h8000_6008);
        txn(64'h5008, WR, PS, 1'b0, 1'b0);
        chk("wt2_cyc", 64'(wt_cyc), 64'd0);
        chk("wt2_lat", 64'(lat), 64'd2);

        // Permissions
        txn(64'h4000_2010, RD, PU, 1'b0, 1'b0);
        chk("u_spage_fault", {63'h0, got_fault}, 64'h1);
        chk("u_spage_lat", 64'(lat), 64'd2);
        chk("u_spage_walk", 64'(walk_cyc), 64'd0);
        bu_ppn = 44'h80007; bu_pte = 64'h53; bu_pte_pa = 64'h8020_0020;
        txn(64'h7000, RD, PU, 1'b0, 1'b0);
        chk("u_fill_pa", tsl_pa, 64'h8000_7000);
        txn(64'h7000, RD, PS, 1'b0, 1'b0);
        chk("s_upage_fault", {63'h0, got_fault}, 64'h1);
        chk("s_upage_ready", {63'h0, got_ready}, 64'h0);
        sum = 1'b1;
        txn(64'h7000, RD, PS, 1'b0, 1'b0);
        chk("s_sum_ready", {63'h0, got_ready}, 64'h1);
        sum = 1'b0;
        txn(64'h4000_2010, WR, PS, 1'b0, 1'b0);
        chk("ro_write_fault", {63'h0, got_fault}, 64'h1);

        // Replacement: entries 0..2 used, fill 3, then evict entry 0, then entry 1
        bu_ppn = 44'h80009; bu_pte = 64'h43;
        txn(64'h9000, RD, PS, 1'b0, 1'b0);
        chk("fill3_walk", 64'(walk_cyc), 64'd3);
        bu_ppn = 44'h8000B;
        txn(64'hB000, RD, PS, 1'b0, 1'b0);
        chk("evict_pa", tsl_pa, 64'h8000_B000);
        txn(64'h5008, RD, PS, 1'b0, 1'b0);
        chk("e1_kept", 64'(walk_cyc), 64'd0);
        bu_ppn = 44'h80005;
        txn(64'h4000_2010, RD, PS, 1'b0, 1'b0);
        chk("e0_evicted", 64'(walk_cyc), 64'd3);
        txn(64'h9000, RD, PS, 1'b0, 1'b0);
        chk("e3_kept", 64'(walk_cyc), 64'd0);
        txn(64'hB000, RD, PS, 1'b0, 1'b0);
        chk("new_kept", 64'(walk_cyc), 64'd0);
        bu_ppn = 44'h80006; bu_pte = 64'h47;
        txn(64'h5008, RD, PS, 1'b0, 1'b0);
        chk("e1_evicted", 64'(walk_cyc), 64'd3);

        // Flush during walk: response still returned, array empty afterwards
        bu_ppn = 44'h8000D; bu_pte = 64'h43;
        txn(64'hD000, RD, PS, 1'b0, 1'b1);
        chk("fw_ready", {63'h0, got_ready}, 64'h1);
        chk("fw_pa", tsl_pa, 64'h8000_D000);
        bu_ppn = 44'h8000B;
        txn(64'hB000, RD, PS, 1'b0, 1'b0);
        chk("fw_cleared_b", 64'(walk_cyc), 64'd3);
        bu_ppn = 44'h8000D;
        txn(64'hD000, RD, PS, 1'b0, 1'b0);
        chk("fw_cleared_d", 64'(walk_cyc), 64'd3);
        txn(64'hD000, RD, PS, 1'b0, 1'b0);
        chk("d_hit", 64'(walk_cyc), 64'd0);
        // Flush in IDLE together with the request
        txn(64'hD000, RD, PS, 1'b1, 1'b0);
        chk("fi_walk", 64'(walk_cyc), 64'd3);

        // Walk fault: no entry written
        bu_fault = 1'b1; bu_ppn = 44'h8000F;
        txn(64'hF000, RD, PS, 1'b0, 1'b0);
        chk("wf_fault", {63'h0, got_fault}, 64'h1);
        chk("wf_ready", {63'h0, got_ready}, 64'h0);
        bu_fault = 1'b0;
        txn(64'hF000, RD, PS, 1'b0, 1'b0);
        chk("wf_nofill", 64'(walk_cyc), 64'd3);
        chk("wf_pa", tsl_pa, 64'h8000_F000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
